wb_arbiter_2m_rr: RTL
=====================

Name: wb_arbiter_2m_rr

Overview:
Two-master Wishbone classic arbiter that shares one slave port (the SoC interconnect/peripheral bus) between the picorv32 instruction/data master and a second master, e.g. a UART debug/loader master.
Arbitration is round-robin with bus ownership held for a whole cycle (cyc_i high).
A watchdog terminates stalled transfers with an error so a hung slave cannot lock the CPU.

Parameters:
AW, 32, address width.
DW, 32, data width; select width is DW/8.
TIMEOUT, 255, max wait cycles for ack/err per strobe; 0 disables the watchdog.
TW, 8, watchdog counter width; TIMEOUT must be < 2^TW.

Ports:
wb_clk_i  in  1  bus clock.
wb_rst_i  in  1  reset, asynchronous, active-high.
m0_adr_i / m1_adr_i  in  AW  master address.
m0_dat_i / m1_dat_i  in  DW  master write data.
m0_sel_i / m1_sel_i  in  DW/8  byte selects.
m0_we_i / m1_we_i  in  1  write enable.
m0_cyc_i / m1_cyc_i  in  1  cycle request.
m0_stb_i / m1_stb_i  in  1  strobe.
m0_dat_o / m1_dat_o  out  DW  read data, equal to s_dat_i.
m0_ack_o / m1_ack_o  out  1  ack, routed to owner only.
m0_err_o / m1_err_o  out  1  error: slave err or watchdog.
s_adr_o  out  AW  slave address.
s_dat_o  out  DW  slave write data.
s_sel_o  out  DW/8  slave byte selects.
s_we_o  out  1  slave write enable.
s_cyc_o  out  1  slave cycle.
s_stb_o  out  1  slave strobe.
s_dat_i  in  DW  slave read data.
s_ack_i  in  1  slave ack.
s_err_i  in  1  slave error.
grant_o  out  2  one-hot owner: 01 = m0, 10 = m1, 00 = idle.

Behaviour:
- Registered state: grant (IDLE/G0/G1), last-served pointer `last`, watchdog count `wd`, timeout flag `to`.
- Reset values: grant=IDLE, last=1 (m0 wins the first tie), wd=0, to=0.
  - All outputs are 0 except m*_dat_o, which follows s_dat_i.
- Arbitration is evaluated every edge where the current owner's cyc_i is low, or grant=IDLE:
  - only m0 requesting -> G0; only m1 requesting -> G1; neither -> IDLE;
  - both requesting -> the master != last.
  - last updates to the newly granted master.
- Owner keeps the grant for every cycle its cyc_i stays high, including multi-beat and idle-stb periods. No preemption.
- Latency:
  - cyc_i rising on a free bus at edge n -> grant at n+1 -> s_cyc_o high in cycle n+1.
  - Handoff: owner drops cyc in cycle k, the other master is requesting -> new grant at edge k+1, no idle cycle.
- Slave mux (combinational from the grant register):
  - s_adr/dat/sel/we = owner's inputs; s_cyc_o = owner cyc_i; s_stb_o = owner stb_i & ~to.
  - IDLE: all s_* outputs are 0.
- Response routing:
  - owner ack_o = s_ack_i; owner err_o = s_err_i | to.
  - The non-owner's ack_o/err_o are 0.
- Watchdog (TIMEOUT>0):
  - wd increments each cycle with s_cyc_o & s_stb_o & ~s_ack_i & ~s_err_i; otherwise wd clears.
  - When wd == TIMEOUT-1 and still no response: to=1 for exactly one cycle, wd clears.
  - While to=1, s_stb_o is forced low.
  - to clears on the next edge unconditionally.
- Simultaneous events: s_ack_i in the same cycle the watchdog would fire -> ack wins, to stays 0.
- Owner drops cyc_i mid-wait: wd clears; any late ack is not forwarded.
- Reset asserted mid-transfer: s_cyc_o/s_stb_o drop immediately (async); grant=IDLE, last=1.

Test Plan:
- Single master: m0 reads adr 0x0000_0010, slave acks in its 2nd stb cycle with 0xDEADBEEF. Required: grant_o=01 one cycle after cyc, m0_ack_o for 1 cycle, m0_dat_o=0xDEADBEEF, m1_ack_o=0.
- Tie after reset: m0 and m1 raise cyc in the same cycle. Required: grant_o=01. After m0 drops cyc, grant_o=10 on the next edge with no IDLE cycle.
- Round-robin: both request continuously with 1-beat cycles. Required: grants alternate 01,10,01,10; neither master is granted twice in a row.
- Lock: m0 holds cyc for 3 back-to-back beats while m1 requests. Required: grant_o stays 01 through all 3 acks; m1 granted only after m0 cyc drops.
- Watchdog: TIMEOUT=4, slave never acks. Required: m0_err_o pulses exactly 1 cycle, 4 cycles after stb, s_stb_o=0 that cycle. Same test with ack in wait cycle 4 -> ack seen, no err.
- Async reset: wb_rst_i pulses mid-wait while m1 is owner. Required: s_cyc_o=0 and grant_o=00 before the next clock edge. After release with both requesting, m0 is granted.

Source files
------------

// File: rtl/wb_arbiter_2m_rr.sv
// Two-master Wishbone classic arbiter: round-robin grant held for a whole cyc,
// one shared slave port, watchdog that ends stalled strobes with an error.
module wb_arbiter_2m_rr #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  // master 0
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  // master 1
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  // shared slave port
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o
);

  localparam logic          WD_EN   = (TIMEOUT != 0);
  localparam logic [TW-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10
  } grant_e;

  grant_e        grant_q, grant_d;
  logic          last_q, last_d;
  logic [TW-1:0] wd_q, wd_d;
  logic          to_q, to_d;

  logic          own_cyc;
  logic          own_stb;
  logic          s_waiting;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      grant_q <= IDLE;
      last_q  <= 1'b1;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
    end
  end

  // Slave-side mux, driven purely from the registered grant.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    own_cyc = 1'b0;
    own_stb = 1'b0;
    unique case (grant_q)
      G0: begin
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_we_o  = m0_we_i;
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i;
      end
      G1: begin
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        s_we_o  = m1_we_i;
        own_cyc = m1_cyc_i;
        own_stb = m1_stb_i;
      end
      default: ;
    endcase
    s_cyc_o = own_cyc;
    s_stb_o = own_stb & ~to_q;
  end

  // Responses reach only an owner that still holds cyc, so a late ack after
  // an abandoned cycle is dropped.
  always_comb begin
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    if (grant_q == G0 && m0_cyc_i) begin
      m0_ack_o = s_ack_i;
      m0_err_o = s_err_i | to_q;
    end
    if (grant_q == G1 && m1_cyc_i) begin
      m1_ack_o = s_ack_i;
      m1_err_o = s_err_i | to_q;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign grant_o  = grant_q;

  always_comb begin
    grant_d = grant_q;
    last_d  = last_q;
    if (!own_cyc) begin
      if (m0_cyc_i && m1_cyc_i) begin
        grant_d = last_q ? G0 : G1;
      end else if (m0_cyc_i) begin
        grant_d = G0;
      end else if (m1_cyc_i) begin
        grant_d = G1;
      end else begin
        grant_d = IDLE;
      end
      if (grant_d == G0) begin
        last_d = 1'b0;
      end else if (grant_d == G1) begin
        last_d = 1'b1;
      end
    end
  end

  // Forced-low stb during the timeout cycle also clears the counter.
  always_comb begin
    s_waiting = s_cyc_o & s_stb_o & ~s_ack_i & ~s_err_i;
    wd_d      = '0;
    to_d      = 1'b0;
    if (WD_EN && s_waiting) begin
      if (wd_q == WD_LAST) begin
        to_d = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

endmodule
